// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle controller: state encoding,
// opcode values, ALU control classes and the opcode-class flags.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_MEMADR  = 4'd3,
    ST_MEMRD   = 4'd4,
    ST_MEMWB   = 4'd5,
    ST_MEMWR   = 4'd6,
    ST_EXEC    = 4'd7,
    ST_ALUWB   = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_IEXEC   = 4'd10,
    ST_IWB     = 4'd11,
    ST_JUMP    = 4'd12,
    ST_ILLEGAL = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_IDLE  = 3'b000;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_AND   = 3'b101;
  localparam logic [2:0] ALU_OR    = 3'b110;
  localparam logic [2:0] ALU_SUB   = 3'b111;

  typedef struct packed {
    logic mem;
    logic rtype;
    logic branch;
    logic imm;
    logic jump;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier feeding the DECODE transition.
// MC_JUMP_EN: when defined, opcode 000010 classifies as jump; otherwise illegal.
module mc_opcode_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = '0;
    case (opcode)
      OP_LW, OP_SW:             op_class.mem    = 1'b1;
      OP_RTYPE:                 op_class.rtype  = 1'b1;
      OP_BEQ:                   op_class.branch = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI: op_class.imm    = 1'b1;
`ifdef MC_JUMP_EN
      OP_J:                     op_class.jump   = 1'b1;
`endif
      default:                  op_class.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle CPU main control FSM: Moore decode of the state into datapath
// enables/selects. MC_JUMP_EN enables the JUMP state (encoding 12).
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       illegal_instr
);

  state_t     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  op_class_t  op_class;

  mc_opcode_decode u_decode (
    .opcode   (opcode),
    .op_class (op_class)
  );

  // NOTE: the opcode register is reset like any other state so that a reset
  // mid-instruction leaves no stale class behind for the next instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Live opcode is captured on the edge leaving DECODE; later states see only opcode_q.
  assign opcode_d = (state_q == ST_DECODE) ? opcode : opcode_q;
  assign state    = state_q;

  always_comb begin
    // NOTE: every output and next-state gets a default first, so no path
    // through the case can infer a latch.
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = ALU_IDLE;
    illegal_instr = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = ST_DECODE;
      end

      ST_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        if (op_class.mem)         state_d = ST_MEMADR;
        else if (op_class.rtype)  state_d = ST_EXEC;
        else if (op_class.branch) state_d = ST_BRANCH;
        else if (op_class.imm)    state_d = ST_IEXEC;
`ifdef MC_JUMP_EN
        else if (op_class.jump)   state_d = ST_JUMP;
`endif
        else                      state_d = ST_ILLEGAL;
      end

      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = (opcode_q == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end

      ST_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = ST_MEMWB;
      end

      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = ST_FETCH;
      end

      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = ST_ALUWB;
      end

      ST_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = ST_FETCH;
      end

      ST_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode_q)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
        state_d = ST_IWB;
      end

      ST_IWB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end

`ifdef MC_JUMP_EN
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = ST_FETCH;
      end
`endif

      ST_ILLEGAL: begin
        illegal_instr = 1'b1;
        state_d       = ST_FETCH;
      end

      // Unused encodings (and JUMP when disabled) recover to FETCH.
      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench for mc_control_fsm; expected values are hand-derived.
// Honours MC_JUMP_EN for the opcode 000010 expectation.
module tb_mc_control_fsm;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic       illegal_instr;

  int n_vec = 0;
  int n_err = 0;

  mc_control_fsm dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .state         (state),
    .illegal_instr (illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [17:0] all_outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                          ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                          alu_src_b, pc_source, alu_op, illegal_instr};
  wire [4:0]  wr_ens   = {pc_write, pc_write_cond, mem_write, ir_write, reg_write};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // From FETCH: present op through DECODE, then scramble the live opcode so
  // later states can only be correct if they use the latched copy.
  task automatic issue(input logic [5:0] op, input logic [3:0] exp_next);
    check("at_fetch", state, 4'd1);
    mem_ready = 1'b1;
    opcode    = op;
    step();
    check("decode_state", state, 4'd2);
    check("decode_srcb", alu_src_b, 2'b11);
    step();
    check("post_decode_state", state, exp_next);
    opcode = 6'h3f;
  endtask

  logic [5:0] imm_ops [3] = '{6'b001000, 6'b001100, 6'b001101};
  logic [2:0] imm_alu [3] = '{3'b100, 3'b101, 3'b110};

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'd0;
    @(negedge clk);
    check("rst_state", state, 4'd0);
    check("rst_outs", all_outs, 18'd0);
    reset_n = 1'b1;
    #1 check("idle_state", state, 4'd0);

    // R-type: 0,1,2,7,8,1
    mem_ready = 1'b1;
    step();
    check("fetch_state", state, 4'd1);
    check("fetch_rd", {mem_read, i_or_d, alu_src_a}, 3'b100);
    check("fetch_srcb", alu_src_b, 2'b01);
    check("fetch_aluop", alu_op, 3'b100);
    check("fetch_irpc", {ir_write, pc_write}, 2'b11);
    step();
    check("rt_decode", state, 4'd2);
    check("rt_decode_regw", reg_write, 1'b0);
    step();
    check("exec_state", state, 4'd7);
    check("exec_sel", {alu_src_a, alu_src_b, alu_op}, {1'b1, 2'b00, 3'b010});
    check("exec_regw", reg_write, 1'b0);
    step();
    check("aluwb_state", state, 4'd8);
    check("aluwb_wr", {reg_write, reg_dst, mem_to_reg}, 3'b110);
    step();
    check("rt_back_fetch", state, 4'd1);

    // FETCH stalls on mem_ready and gates ir_write/pc_write.
    mem_ready = 1'b0;
    #1 check("fetch_stall_irpc", {ir_write, pc_write}, 2'b00);
    check("fetch_stall_rd", mem_read, 1'b1);
    step();
    check("fetch_stall_state", state, 4'd1);

    // Load with three stalled MEMRD cycles.
    issue(6'b100011, 4'd3);
    check("memadr_sel", {alu_src_a, alu_src_b, alu_op}, {1'b1, 2'b10, 3'b100});
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check("memrd_hold", state, 4'd4);
      check("memrd_sel", {mem_read, i_or_d}, 2'b11);
      step();
    end
    check("memrd_last", state, 4'd4);
    mem_ready = 1'b1;
    step();
    check("memwb_state", state, 4'd5);
    check("memwb_wr", {reg_write, mem_to_reg, reg_dst}, 3'b110);
    step();
    check("lw_back_fetch", state, 4'd1);

    // Store with one stalled MEMWR cycle.
    issue(6'b101011, 4'd3);
    mem_ready = 1'b0;
    step();
    check("memwr_state", state, 4'd6);
    check("memwr_sel", {mem_write, i_or_d, mem_read}, 3'b110);
    mem_ready = 1'b1;
    step();
    check("sw_back_fetch", state, 4'd1);

    // Branch.
    issue(6'b000100, 4'd9);
    check("branch_sel", {alu_src_a, alu_src_b, alu_op, pc_write_cond, pc_source},
          {1'b1, 2'b00, 3'b111, 1'b1, 2'b01});
    check("branch_pcw", pc_write, 1'b0);
    step();
    check("br_back_fetch", state, 4'd1);

    // Immediates: alu_op from the latched opcode.
    for (int i = 0; i < 3; i++) begin
      issue(imm_ops[i], 4'd10);
      check("iexec_aluop", alu_op, imm_alu[i]);
      check("iexec_src", {alu_src_a, alu_src_b}, 3'b110);
      step();
      check("iwb_state", state, 4'd11);
      check("iwb_wr", {reg_write, reg_dst, mem_to_reg}, 3'b100);
      step();
    end

    // Unsupported opcode.
    issue(6'b111111, 4'd13);
    check("illegal_pulse", illegal_instr, 1'b1);
    check("illegal_noen", wr_ens, 5'd0);
    step();
    check("illegal_after", {state, illegal_instr}, {4'd1, 1'b0});

    // Jump opcode.
`ifdef MC_JUMP_EN
    issue(6'b000010, 4'd12);
    check("jump_sel", {pc_write, pc_source}, 3'b110);
    check("jump_noill", illegal_instr, 1'b0);
`else
    issue(6'b000010, 4'd13);
    check("j_illegal_pulse", illegal_instr, 1'b1);
    check("j_illegal_noen", wr_ens, 5'd0);
`endif
    step();
    check("j_back_fetch", state, 4'd1);

    // Asynchronous reset during a MEMWR wait.
    issue(6'b101011, 4'd3);
    mem_ready = 1'b0;
    step();
    check("pre_rst_memwr", {state, mem_write}, {4'd6, 1'b1});
    #2 reset_n = 1'b0;
    #1 check("async_rst_state", state, 4'd0);
    check("async_rst_outs", all_outs, 18'd0);
    @(negedge clk);
    check("held_rst_state", state, 4'd0);
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    step();
    check("resume_fetch", state, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port `opcode`, input, 6 bits: instruction bits [31:26], sampled in DECODE.
REQ-004 SHALL have port `mem_ready`, input, 1 bit: memory access completes in the current cycle.
REQ-005 SHALL have ports `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`, all outputs, 1 bit each: datapath enables and selects.
REQ-006 SHALL have ports `alu_src_b` and `pc_source`, outputs, 2 bits each. `alu_src_b`: 00=B, 01=constant 4, 10=sign-extended immediate, 11=immediate shifted left by 2. `pc_source`: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-007 SHALL have port `alu_op`, output, 3 bits: ALU control class. 100=add, 111=subtract, 101=and, 110=or, 010=R-type funct decode, 000=idle.
REQ-008 SHALL have port `state`, output, 4 bits: current state encoding.
REQ-009 SHALL have port `illegal_instr`, output, 1 bit: one-cycle pulse on an unsupported opcode.

Function
REQ-010 SHALL encode states as IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, IEXEC=10, IWB=11, JUMP=12, ILLEGAL=13; encodings 14–15 SHALL go to FETCH.
REQ-011 SHALL drive outputs as a Moore decode of the state. Only `ir_write` and `pc_write` in FETCH SHALL be gated by `mem_ready`.
REQ-012 In IDLE, all outputs SHALL be 0; the next state SHALL be FETCH unconditionally.
REQ-013 In FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=100, `pc_source`=00, `ir_write`=`pc_write`=`mem_ready`. Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
REQ-014 In DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=100. Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 001000, 001100 or 001101 -> IEXEC
  - 000010 -> JUMP (see REQ-025)
  - any other opcode -> ILLEGAL
REQ-015 In MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=100. Go to MEMRD for 100011, else MEMWR.
REQ-016 In MEMRD: `mem_read`=1, `i_or_d`=1. Wait for `mem_ready`=1, then go to MEMWB.
REQ-017 In MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0; then go to FETCH.
REQ-018 In MEMWR: `mem_write`=1, `i_or_d`=1. Wait for `mem_ready`=1, then go to FETCH. `mem_write` SHALL stay high throughout the wait.
REQ-019 In EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010; then go to ALUWB. In ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0; then go to FETCH.
REQ-020 In BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=111, `pc_write_cond`=1, `pc_source`=01; then go to FETCH.
REQ-021 In IEXEC: `alu_src_a`=1, `alu_src_b`=10. `alu_op` SHALL use the opcode latched in DECODE: 100 for 001000, 101 for 001100, 110 for 001101. Then go to IWB. In IWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0; then go to FETCH.
REQ-022 In ILLEGAL: `illegal_instr`=1 for exactly one cycle, no write enables asserted; then go to FETCH.
REQ-023 The opcode SHALL be latched into an internal register at DECODE; later states SHALL use only the latched copy.

Reset
REQ-024 Asserting `reset_n`=0 at any time, including mid-wait in FETCH, MEMRD or MEMWR, SHALL force IDLE and the latched opcode to 0 immediately. All outputs SHALL then be 0 and `state`=0; release SHALL resume at IDLE.

Configuration
REQ-025 Macro `MC_JUMP_EN`:
  - Defined: opcode 000010 goes to JUMP, which asserts `pc_write`=1 and `pc_source`=10, then goes to FETCH.
  - Undefined: 000010 goes to ILLEGAL, and state 12 is unreachable and treated as an invalid encoding (-> FETCH).

Structure
REQ-026 Shared package `mc_ctrl_pkg` SHALL hold the state enum, opcode constants, and `alu_op` class constants.
REQ-027 Sub-module `mc_opcode_decode` SHALL be a combinational opcode classifier (mem/rtype/branch/imm/jump/illegal) used by DECODE.

Verification
REQ-028 Release reset, `mem_ready`=1, opcode 000000 -> state sequence 0,1,2,7,8,1; `reg_write`=1 and `reg_dst`=1 only in state 8.
REQ-029 Opcode 100011 with `mem_ready` low for 3 cycles in MEMRD -> state 4 held 4 cycles, then 5 with `mem_to_reg`=1.
REQ-030 Opcode 001101 -> `alu_op`=110 in IEXEC; opcode 001100 -> 101; opcode 001000 -> 100.
REQ-031 Opcode 111111 -> state 13 for 1 cycle, `illegal_instr` pulses once, no write enables; without `MC_JUMP_EN`, 000010 produces the same response.
REQ-032 `reset_n` asserted during a MEMWR wait -> `mem_write` drops to 0 and state=0 without waiting for a clock edge.
